// File: rtl/noc_input_queue.sv
// ---------------------------------------------------------------------------
// noc_input_queue
//   Router input-port flit queue. Buffers DATA_W-bit flits together with
//   their one-hot output-port request and presents the head entry to the
//   switch allocator. Provides occupancy, full/empty indication, a sticky
//   overflow flag and an optional credit-return pulse.
//
// Parameters
//   DATA_W     flit width in bits
//   DEPTH      number of entries (power of two, >= 2)
//   NUM_PORTS  router output ports (width of the one-hot port request)
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst         in   asynchronous active-low reset
//   valid_i     in   push request for data_i / req_port_i
//   data_i      in   incoming flit
//   req_port_i  in   one-hot output-port request of the incoming flit
//   pop_req_i   in   allocator grant, removes the head flit
//   data_o      out  head flit, zero when empty
//   req_port_o  out  head flit port request, zero when empty
//   en_o        out  head valid (queue not empty)
//   full_o      out  occupancy equals DEPTH
//   count_o     out  current occupancy
//   ovf_o       out  sticky: push attempted while full
//   credit_o    out  credit return pulse
//
// Build option
//   QUEUE_CREDIT_EN  when defined, credit_o is a registered copy of the
//                    accepted-pop strobe; otherwise credit_o is tied low.
// ---------------------------------------------------------------------------
module noc_input_queue #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int NUM_PORTS = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic [NUM_PORTS-1:0]         req_port_i,
    input  logic                         pop_req_i,
    output logic [DATA_W-1:0]            data_o,
    output logic [NUM_PORTS-1:0]         req_port_o,
    output logic                         en_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         ovf_o,
    output logic                         credit_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = DATA_W + NUM_PORTS;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    // Each entry holds {flit, port request}
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic             w_en;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_en   = (r_count != {CNT_W{1'b0}});
    assign w_full = (r_count == CNT_DEPTH);
    // Fullness is judged on the registered count: a same-cycle pop never
    // frees a slot for the incoming flit.
    assign w_push = valid_i && !w_full;
    assign w_pop  = pop_req_i && w_en;

    // Entry storage: write the accepted flit at the write pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {ENT_W{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {data_i, req_port_i};
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? {PTR_W{1'b0}} : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? {PTR_W{1'b0}} : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (valid_i && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Head presentation: combinational read, zeroed while empty
    always_comb begin
        data_o     = {DATA_W{1'b0}};
        req_port_o = {NUM_PORTS{1'b0}};
        if (w_en) begin
            {data_o, req_port_o} = r_mem[r_rd_ptr];
        end else begin
            data_o     = {DATA_W{1'b0}};
            req_port_o = {NUM_PORTS{1'b0}};
        end
    end

    assign en_o    = w_en;
    assign full_o  = w_full;
    assign count_o = r_count;
    assign ovf_o   = r_ovf;

`ifdef QUEUE_CREDIT_EN
    logic r_credit;

    // Credit pulse follows each accepted pop by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop;
        end
    end

    assign credit_o = r_credit;
`else
    assign credit_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_input_queue.sv
module tb_noc_input_queue;

    localparam int DATA_W    = 16;
    localparam int DEPTH     = 4;
    localparam int NUM_PORTS = 5;

    logic                  clk;
    logic                  rst;
    logic                  valid_i;
    logic [DATA_W-1:0]     data_i;
    logic [NUM_PORTS-1:0]  req_port_i;
    logic                  pop_req_i;
    logic [DATA_W-1:0]     data_o;
    logic [NUM_PORTS-1:0]  req_port_o;
    logic                  en_o;
    logic                  full_o;
    logic [2:0]            count_o;
    logic                  ovf_o;
    logic                  credit_o;

    noc_input_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_PORTS(NUM_PORTS)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i),
        .req_port_i(req_port_i), .pop_req_i(pop_req_i), .data_o(data_o),
        .req_port_o(req_port_o), .en_o(en_o), .full_o(full_o),
        .count_o(count_o), .ovf_o(ovf_o), .credit_o(credit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for a given cycle, sampled at that cycle's falling edge
    typedef struct {
        int                   cyc;
        logic [DATA_W-1:0]    data;
        logic [NUM_PORTS-1:0] port;
        logic                 en;
        logic                 full;
        logic [2:0]           count;
        logic                 ovf;
        logic                 credit;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0]    data;
        logic [NUM_PORTS-1:0] port;
    } flit_t;

    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: an unbounded-capable queue capped at DEPTH
    flit_t m_q[$];
    logic  m_ovf    = 1'b0;
    logic  m_credit = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t model_outputs(input int c);
        exp_t e;
        e.cyc   = c;
        e.en    = (m_q.size() != 0);
        e.data  = e.en ? m_q[0].data : '0;
        e.port  = e.en ? m_q[0].port : '0;
        e.full  = (m_q.size() == DEPTH);
        e.count = 3'(m_q.size());
        e.ovf   = m_ovf;
`ifdef QUEUE_CREDIT_EN
        e.credit = m_credit;
`else
        e.credit = 1'b0;
`endif
        return e;
    endfunction

    // Apply one clock edge worth of behaviour to the reference model
    task automatic model_edge(input logic v, input logic [DATA_W-1:0] d,
                              input logic [NUM_PORTS-1:0] p, input logic pop);
        logic was_full, was_empty;
        flit_t f;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (pop && !was_empty) void'(m_q.pop_front());
        if (v && !was_full) begin
            f.data = d;
            f.port = p;
            m_q.push_back(f);
        end
        if (v && was_full) m_ovf = 1'b1;
        m_credit = pop && !was_empty;
    endtask

    // One cycle: drive inputs, record expected outputs for this cycle, advance
    task automatic step(input logic v, input logic [DATA_W-1:0] d,
                        input logic [NUM_PORTS-1:0] p, input logic pop);
        valid_i    = v;
        data_i     = d;
        req_port_i = p;
        pop_req_i  = pop;
        exp_q.push_back(model_outputs(cyc));
        model_edge(v, d, p, pop);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle with traffic still driven
    task automatic mid_reset();
        valid_i    = 1'b1;
        data_i     = 16'hDEAD;
        req_port_i = 5'b00001;
        pop_req_i  = 1'b1;
        #2;
        rst = 1'b0;
        m_q.delete();
        m_ovf    = 1'b0;
        m_credit = 1'b0;
        exp_q.push_back(model_outputs(cyc));
        @(posedge clk);
        #1;
        exp_q.push_back(model_outputs(cyc));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compare DUT outputs against queued expectations
    exp_t e;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            chk("exp_cycle", 32'(e.cyc), 32'(cyc));
            chk("data_o",     32'(data_o),     32'(e.data));
            chk("req_port_o", 32'(req_port_o), 32'(e.port));
            chk("en_o",       32'(en_o),       32'(e.en));
            chk("full_o",     32'(full_o),     32'(e.full));
            chk("count_o",    32'(count_o),    32'(e.count));
            chk("ovf_o",      32'(ovf_o),      32'(e.ovf));
            chk("credit_o",   32'(credit_o),   32'(e.credit));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_PORTS-1:0] rp;
        rst        = 1'b0;
        valid_i    = 1'b0;
        data_i     = '0;
        req_port_i = '0;
        pop_req_i  = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(model_outputs(cyc));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Partial fill to three entries, then reset mid-traffic
        step(1'b1, 16'h1111, 5'b00001, 1'b0);
        step(1'b1, 16'h2222, 5'b00010, 1'b0);
        step(1'b1, 16'h3333, 5'b00100, 1'b0);
        mid_reset();

        // Fill to full, fifth push dropped and overflow raised
        step(1'b1, 16'hA001, 5'b00001, 1'b0);
        step(1'b1, 16'hA002, 5'b00010, 1'b0);
        step(1'b1, 16'hA003, 5'b00100, 1'b0);
        step(1'b1, 16'hA004, 5'b01000, 1'b0);
        step(1'b1, 16'hA005, 5'b10000, 1'b0);
        step(1'b0, 16'h0000, 5'b00000, 1'b0);

        // Drain in order, then a wrapped push
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 5'b00000, 1'b1);
        step(1'b1, 16'hB001, 5'b00010, 1'b0);
        step(1'b1, 16'hC001, 5'b00100, 1'b0);

        // Push+pop at count 2: occupancy holds, head advances
        step(1'b1, 16'hC002, 5'b01000, 1'b1);
        step(1'b0, 16'h0000, 5'b00000, 1'b0);

        // Clear overflow, refill, then push+pop while full
        mid_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hD001 + i), 5'(1 << i), 1'b0);
        step(1'b1, 16'hD0FF, 5'b10000, 1'b1);
        step(1'b0, 16'h0000, 5'b00000, 1'b0);

        // Three consecutive pops (credit burst), then pops on empty
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 5'b00000, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 5'b00000, 1'b1);
        step(1'b0, 16'h0000, 5'b00000, 1'b0);

        // Randomised traffic, including occasional non-one-hot requests
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) rp = 5'($urandom);
            else                           rp = 5'(1 << $urandom_range(0, 4));
            step(1'($urandom_range(0, 99) < 55), 16'($urandom), rp,
                 1'($urandom_range(0, 99) < 45));
        end
        step(1'b0, 16'h0000, 5'b00000, 1'b0);

        @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
